mouse_position_tracker: RTL and testbench
=========================================

Name: mouse_position_tracker

Overview:
Upstream stage of the mouse pixel drawer. It consumes received PS/2 mouse bytes from the PS/2 receiver and assembles them into standard 3-byte movement packets. It accumulates the signed X/Y deltas into an absolute cursor position, clamped to the screen, and produces the mouse_x/mouse_y positions and draw enable that the drawer consumes.

Parameters:
COLUMNS, 640, screen width in pixels; X range 0..COLUMNS-1
ROWS, 480, screen height in pixels; Y range 0..ROWS-1
X_INIT, COLUMNS/2, X position after reset
Y_INIT, ROWS/2, Y position after reset
TIMEOUT_CYCLES, 2000000, maximum inter-byte gap in clk cycles inside a packet before the partial packet is discarded

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous active-high reset
rx_data_i  input  8  received PS/2 byte; valid only when rx_done_tick_i=1
rx_done_tick_i  input  1  one-cycle strobe: rx_data_i holds a new byte
mouse_x_position_o  output  $clog2(COLUMNS)  registered cursor X, screen coords
mouse_y_position_o  output  $clog2(ROWS)  registered cursor Y, screen coords (0 = top)
left_button_o  output  1  registered left button state
right_button_o  output  1  registered right button state
draw_en_o  output  1  equals left_button_o; drives drawer draw enable
packet_done_tick_o  output  1  one-cycle strobe; first cycle updated outputs are visible

Behaviour:
- Reset (async, reset_i=1): state IDLE; X=X_INIT, Y=Y_INIT; both buttons 0; draw_en_o=0; packet_done_tick_o=0; timeout counter 0; byte registers 0.
- FSM states: IDLE, BYTE1, BYTE2, UPDATE.
- IDLE, tick with rx_data_i[3]=1: store byte0, go to BYTE1.
- IDLE, tick with rx_data_i[3]=0: discard the byte and stay in IDLE. This is the packet resync rule.
- BYTE1, tick: store as X delta byte, go to BYTE2.
- BYTE2, tick: store as Y delta byte, go to UPDATE.
- UPDATE: lasts exactly one cycle, then returns to IDLE.
  - Registers the new X, Y and buttons; asserts packet_done_tick_o on the next cycle together with the new values.
  - Latency from the byte2 tick to new outputs is 2 cycles.
  - A tick arriving while in UPDATE is evaluated as a byte0 candidate under the IDLE rules.
- Timeout:
  - In BYTE1 and BYTE2 the counter increments every cycle without a tick, and clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE, discarding the partial packet. Outputs are unchanged.
  - The counter is held at 0 in IDLE and UPDATE.
- byte0 fields: [0] left button, [1] right button, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Deltas:
  - dx = 9-bit two's complement {byte0[4], byte1}, range -256..255.
  - dy = 9-bit two's complement {byte0[5], byte2}, range -256..255.
  - If an axis's overflow bit is set, that axis's delta is forced to 0. The other axis and the buttons still update.
- Arithmetic:
  - Signed, in a width wide enough for position±256 without wrap: max(clog2(COLUMNS), clog2(ROWS)) + 2 bits.
  - X_new = X + dx.
  - Y_new = Y - dy. PS/2 +Y is up; screen +Y is down.
- Clamping: results <0 become 0; X results >COLUMNS-1 become COLUMNS-1; Y results >ROWS-1 become ROWS-1. No wrap-around ever.
- Outputs change only in the cycle after UPDATE, or on reset. All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-packet: all partial-packet state is lost, and the next byte is treated under the IDLE rules.

Test Plan:
1. Release reset, no ticks -> X=320, Y=240, buttons 0, draw_en_o=0, packet_done_tick_o never high.
2. Bytes 0x09,0x0A,0x05 -> 2 cycles after the last tick: X=330, Y=235, left=1, draw_en_o=1, packet_done_tick_o high for exactly 1 cycle.
3. From reset, bytes 0x38,0xF6,0xFB (dx=-10, dy=-5) -> X=310, Y=245, buttons 0. Then 0x08,0xFF,0x00 sent three times -> X saturates at 639 and does not wrap. Then 0x08,0x00,0xFF twice -> Y=0.
4. From reset, bytes 0x48,0x10,0x10 (X overflow set) -> X=320, Y=224. Then 0x8A,0x05,0x7F (Y overflow set) -> X=325, Y=224, right=1.
5. From reset, byte 0x00 then 0x09,0x01,0x00 -> 0x00 dropped; X=321, Y=240, left=1, exactly one packet_done_tick_o.
6. From reset:
   - 0x08, then TIMEOUT_CYCLES idle cycles, then 0x09,0x01,0x00 -> X=321, Y=240, left=1.
   - Separately, assert reset_i between byte1 and byte2 -> outputs return to 320/240, and no packet_done_tick_o fires for the interrupted packet.

Source files
------------

// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: assembles 3-byte PS/2 movement packets and tracks a
// clamped absolute cursor position plus button state for the pixel drawer.
module mouse_position_tracker #(
    parameter int unsigned COLUMNS        = 640,
    parameter int unsigned ROWS           = 480,
    parameter int unsigned X_INIT         = COLUMNS / 2,
    parameter int unsigned Y_INIT         = ROWS / 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [7:0]                  rx_data_i,
    input  logic                        rx_done_tick_i,
    output logic [$clog2(COLUMNS)-1:0]  mouse_x_position_o,
    output logic [$clog2(ROWS)-1:0]     mouse_y_position_o,
    output logic                        left_button_o,
    output logic                        right_button_o,
    output logic                        draw_en_o,
    output logic                        packet_done_tick_o
);

    localparam int unsigned XW = $clog2(COLUMNS);
    localparam int unsigned YW = $clog2(ROWS);
    localparam int unsigned PW = (XW > YW) ? XW : YW;
    // Wide enough for position +/- 256 without wrap, never narrower than the delta.
    localparam int unsigned AW = ((PW > 8) ? PW : 8) + 2;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYTE1  = 2'd1,
        BYTE2  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      byte0_q;
    logic [7:0]      byte1_q;
    logic [7:0]      byte2_q;
    logic [TW-1:0]   timeout_q;

    logic signed [8:0]    dx9_c;
    logic signed [8:0]    dy9_c;
    logic signed [AW-1:0] dx_c;
    logic signed [AW-1:0] dy_c;
    logic signed [AW-1:0] x_sum_c;
    logic signed [AW-1:0] y_sum_c;
    logic [XW-1:0]        x_next_c;
    logic [YW-1:0]        y_next_c;
    logic                 byte0_ok_c;
    logic                 timeout_hit_c;

    assign byte0_ok_c    = rx_done_tick_i && rx_data_i[3];
    assign timeout_hit_c = (timeout_q == TW'(TIMEOUT_CYCLES - 1));

    // Signed deltas from the stored packet, accumulated and clamped to the screen.
    always_comb begin
        dx9_c    = $signed({byte0_q[4], byte1_q});
        dy9_c    = $signed({byte0_q[5], byte2_q});
        dx_c     = '0;
        dy_c     = '0;
        if (!byte0_q[6]) begin
            dx_c = AW'(dx9_c);
        end
        if (!byte0_q[7]) begin
            dy_c = AW'(dy9_c);
        end
        // Screen Y grows downward while PS/2 +Y is up.
        x_sum_c  = $signed(AW'(mouse_x_position_o)) + dx_c;
        y_sum_c  = $signed(AW'(mouse_y_position_o)) - dy_c;

        if (x_sum_c[AW-1]) begin
            x_next_c = '0;
        end else if (x_sum_c > $signed(AW'(COLUMNS - 1))) begin
            x_next_c = XW'(COLUMNS - 1);
        end else begin
            x_next_c = XW'(x_sum_c);
        end

        if (y_sum_c[AW-1]) begin
            y_next_c = '0;
        end else if (y_sum_c > $signed(AW'(ROWS - 1))) begin
            y_next_c = YW'(ROWS - 1);
        end else begin
            y_next_c = YW'(y_sum_c);
        end
    end

    // Packet FSM with inter-byte timeout and registered position/button outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q            <= IDLE;
            byte0_q            <= '0;
            byte1_q            <= '0;
            byte2_q            <= '0;
            timeout_q          <= '0;
            mouse_x_position_o <= XW'(X_INIT);
            mouse_y_position_o <= YW'(Y_INIT);
            left_button_o      <= 1'b0;
            right_button_o     <= 1'b0;
            draw_en_o          <= 1'b0;
            packet_done_tick_o <= 1'b0;
        end else begin
            packet_done_tick_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    timeout_q <= '0;
                    // Bytes without bit 3 set cannot start a packet: resync.
                    if (byte0_ok_c) begin
                        byte0_q <= rx_data_i;
                        state_q <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (rx_done_tick_i) begin
                        byte1_q   <= rx_data_i;
                        timeout_q <= '0;
                        state_q   <= BYTE2;
                    end else if (timeout_hit_c) begin
                        timeout_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        timeout_q <= timeout_q + TW'(1);
                    end
                end
                BYTE2: begin
                    if (rx_done_tick_i) begin
                        byte2_q   <= rx_data_i;
                        timeout_q <= '0;
                        state_q   <= UPDATE;
                    end else if (timeout_hit_c) begin
                        timeout_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        timeout_q <= timeout_q + TW'(1);
                    end
                end
                UPDATE: begin
                    timeout_q          <= '0;
                    mouse_x_position_o <= x_next_c;
                    mouse_y_position_o <= y_next_c;
                    left_button_o      <= byte0_q[0];
                    right_button_o     <= byte0_q[1];
                    draw_en_o          <= byte0_q[0];
                    packet_done_tick_o <= 1'b1;
                    // A byte landing here is already the next packet's header candidate.
                    if (byte0_ok_c) begin
                        byte0_q <= rx_data_i;
                        state_q <= BYTE1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker: vector table plus hand sequences, scoreboarded on packet_done_tick_o.
module tb_mouse_position_tracker;

    localparam int unsigned COLUMNS = 640;
    localparam int unsigned ROWS    = 480;
    localparam int unsigned TO      = 40;
    localparam int unsigned XW      = $clog2(COLUMNS);
    localparam int unsigned YW      = $clog2(ROWS);

    typedef struct {
        int unsigned x;
        int unsigned y;
        logic        l;
        logic        r;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        exp_t        e;
    } vec_t;

    logic          clk;
    logic          reset_i;
    logic [7:0]    rx_data_i;
    logic          rx_done_tick_i;
    logic [XW-1:0] mouse_x_position_o;
    logic [YW-1:0] mouse_y_position_o;
    logic          left_button_o;
    logic          right_button_o;
    logic          draw_en_o;
    logic          packet_done_tick_o;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t cur;
    exp_t init_e;
    vec_t vecs[12];

    mouse_position_tracker #(
        .COLUMNS        (COLUMNS),
        .ROWS           (ROWS),
        .X_INIT         (COLUMNS / 2),
        .Y_INIT         (ROWS / 2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .rx_data_i          (rx_data_i),
        .rx_done_tick_i     (rx_done_tick_i),
        .mouse_x_position_o (mouse_x_position_o),
        .mouse_y_position_o (mouse_y_position_o),
        .left_button_o      (left_button_o),
        .right_button_o     (right_button_o),
        .draw_en_o          (draw_en_o),
        .packet_done_tick_o (packet_done_tick_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk_e(int unsigned x, int unsigned y, logic l, logic r);
        exp_t e;
        e.x = x;
        e.y = y;
        e.l = l;
        e.r = r;
        return e;
    endfunction

    function automatic vec_t mk_v(logic rst, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                  int unsigned x, int unsigned y, logic l, logic r);
        vec_t v;
        v.rst = rst;
        v.b0  = b0;
        v.b1  = b1;
        v.b2  = b2;
        v.e   = mk_e(x, y, l, r);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_out(input string name, input exp_t e);
        checks++;
        if (32'(mouse_x_position_o) !== e.x || 32'(mouse_y_position_o) !== e.y ||
            left_button_o !== e.l || right_button_o !== e.r || draw_en_o !== e.l) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d l=%b r=%b en=%b expected x=%0d y=%0d l=%b r=%b en=%b",
                     name, mouse_x_position_o, mouse_y_position_o, left_button_o,
                     right_button_o, draw_en_o, e.x, e.y, e.l, e.r, e.l);
        end
    endtask

    // Scoreboard: every done tick consumes one expected packet; otherwise outputs must hold.
    always @(negedge clk) begin
        if (reset_i) begin
            check_out("reset_state", init_e);
            chk("reset_done_tick", 32'(packet_done_tick_o), 0);
        end else if (packet_done_tick_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_tick: got done=1 expected no packet at x=%0d y=%0d",
                         mouse_x_position_o, mouse_y_position_o);
            end else begin
                cur = exp_q.pop_front();
                check_out("packet", cur);
            end
        end else begin
            check_out("hold", cur);
        end
    end

    // Drive one byte for exactly one sampled edge, then gap idle cycles with junk data.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data_i      = b;
        rx_done_tick_i = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick_i = 1'b0;
        rx_data_i      = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, 0);
    endtask

    task automatic apply_reset();
        reset_i        = 1'b1;
        rx_done_tick_i = 1'b0;
        exp_q.delete();
        cur            = init_e;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        init_e         = mk_e(COLUMNS / 2, ROWS / 2, 1'b0, 1'b0);
        cur            = init_e;
        reset_i        = 1'b1;
        rx_done_tick_i = 1'b0;
        rx_data_i      = 8'h00;

        vecs[0]  = mk_v(1'b1, 8'h09, 8'h0A, 8'h05, 330, 235, 1'b1, 1'b0);
        vecs[1]  = mk_v(1'b1, 8'h38, 8'hF6, 8'hFB, 310, 245, 1'b0, 1'b0);
        vecs[2]  = mk_v(1'b0, 8'h08, 8'hFF, 8'h00, 565, 245, 1'b0, 1'b0);
        vecs[3]  = mk_v(1'b0, 8'h08, 8'hFF, 8'h00, 639, 245, 1'b0, 1'b0);
        vecs[4]  = mk_v(1'b0, 8'h08, 8'hFF, 8'h00, 639, 245, 1'b0, 1'b0);
        vecs[5]  = mk_v(1'b0, 8'h08, 8'h00, 8'hFF, 639, 0,   1'b0, 1'b0);
        vecs[6]  = mk_v(1'b0, 8'h08, 8'h00, 8'hFF, 639, 0,   1'b0, 1'b0);
        vecs[7]  = mk_v(1'b1, 8'h48, 8'h10, 8'h10, 320, 224, 1'b0, 1'b0);
        vecs[8]  = mk_v(1'b0, 8'h8A, 8'h05, 8'h7F, 325, 224, 1'b0, 1'b1);
        vecs[9]  = mk_v(1'b1, 8'h18, 8'h00, 8'h00, 64,  240, 1'b0, 1'b0);
        vecs[10] = mk_v(1'b0, 8'h18, 8'h00, 8'h00, 0,   240, 1'b0, 1'b0);
        vecs[11] = mk_v(1'b0, 8'h28, 8'h00, 8'h00, 0,   479, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Idle after reset: outputs hold at the initial position, no done tick.
        repeat (20) @(posedge clk);
        #1;

        // Two-cycle latency from the last byte to visible outputs.
        exp_q.push_back(mk_e(330, 235, 1'b1, 1'b0));
        send_packet(8'h09, 8'h0A, 8'h05, 1);
        @(negedge clk);
        chk("latency_cycle1_done", 32'(packet_done_tick_o), 0);
        @(negedge clk);
        chk("latency_cycle2_done", 32'(packet_done_tick_o), 1);
        #1;
        drain(10);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst) apply_reset();
            exp_q.push_back(vecs[i].e);
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, int'($urandom_range(0, 2)));
            drain(10);
        end

        // A header byte without bit 3 is dropped.
        apply_reset();
        send_byte(8'h00, 1);
        exp_q.push_back(mk_e(321, 240, 1'b1, 1'b0));
        send_packet(8'h09, 8'h01, 8'h00, 1);
        drain(10);
        repeat (5) @(posedge clk);
        #1;

        // Partial packet discarded after a full timeout gap.
        apply_reset();
        send_byte(8'h08, int'(TO));
        exp_q.push_back(mk_e(321, 240, 1'b1, 1'b0));
        send_packet(8'h09, 8'h01, 8'h00, 0);
        drain(10);

        // Gaps just under the timeout keep the packet alive.
        exp_q.push_back(mk_e(323, 240, 1'b1, 1'b0));
        send_byte(8'h09, int'(TO) - 2);
        send_byte(8'h02, int'(TO) - 2);
        send_byte(8'h00, 0);
        drain(10);

        // Header arriving in the update cycle starts the next packet.
        apply_reset();
        exp_q.push_back(mk_e(321, 240, 1'b1, 1'b0));
        exp_q.push_back(mk_e(323, 240, 1'b0, 1'b0));
        send_packet(8'h09, 8'h01, 8'h00, 0);
        send_packet(8'h08, 8'h02, 8'h00, 0);
        drain(10);

        // Reset between byte1 and byte2 loses the partial packet.
        apply_reset();
        send_byte(8'h09, 1);
        send_byte(8'h05, 1);
        apply_reset();
        repeat (10) @(posedge clk);
        #1;
        send_byte(8'h04, 1);
        exp_q.push_back(mk_e(323, 240, 1'b0, 1'b0));
        send_packet(8'h08, 8'h03, 8'h00, 1);
        drain(10);
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
